meta_extract: RTL and testbench
===============================

// Module: meta_extract
// PURPOSE
//  Receive side of the metadata-over-Ethernet link. Accepts 512-bit
//  Avalon-ST frames from the mux/network path and validates the
//  minimum-size metadata frame header. Unpacks metadata_t and delivers it
//  on a valid/ready metadata stream through a 2-entry output buffer.
//  Drops and counts malformed or foreign frames.
// PARAMETERS
//  DST_MAC_P  48'h(DST_MAC)  expected destination MAC, frame bits [511:464]
//  SRC_MAC_P  48'h(SRC_MAC)  expected source MAC, bits [463:416]
//  ETH_TYPE_P 16'h(ETH_META) expected ethertype, bits [415:400]
//  META_W     252            metadata_t width, bits [399:148]; [147:0] pad, ignored
//  CNT_W      32             width of statistics counters
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  in_data        in   512     frame beat, byte 0 at [511:504]
//  in_valid       in   1       beat valid
//  in_sop         in   1       start of packet
//  in_eop         in   1       end of packet
//  in_empty       in   6       empty bytes on eop beat
//  in_ready       out  1       beat accepted when in_valid&in_ready
//  out_meta_data  out  META_W  extracted metadata_t
//  out_meta_valid out  1       metadata valid
//  out_meta_ready in   1       downstream accepts
//  stat_pkt_cnt   out  CNT_W   frames delivered (wraps)
//  stat_drop_cnt  out  CNT_W   frames/orphan beats dropped (wraps)
// BEHAVIOUR
//  Reset: in_ready=0 during reset, 1 on the first cycle after; buffer empty;
//   out_meta_valid=0, out_meta_data=0; both counters=0; FSM=IDLE.
//  in_ready = (buffer occupancy < 2), from the registered count only.
//   No combinational path from out_meta_ready.
//  FSM IDLE: on an accepted beat, classify:
//   sop&eop&empty==0&header match -> push in_data[399:148], pkt_cnt++.
//   sop&eop, but header or empty mismatch -> discard, drop_cnt++.
//   sop&!eop (multi-beat frame) -> discard, drop_cnt++, go to DROP.
//   !sop (orphan beat) -> discard, drop_cnt++; a !sop&!eop beat also goes to DROP.
//  FSM DROP: discard accepted beats without counting; eop -> IDLE.
//   A sop while in DROP: drop_cnt++, stay in DROP (or go to IDLE if eop).
//  Latency: an accepted good frame appears on out_meta_valid the next cycle
//   (buffer was empty) and is held stable until out_meta_ready.
//  Buffer: 2-entry FIFO, in-order.
//   Push and pop in the same cycle with occupancy 1 or 2 -> occupancy unchanged.
//   No push is ever lost, because in_ready gates acceptance.
//  Counters increment by 1 and wrap at 2^CNT_W.
//   They update one cycle after the accepting beat.
//  Mid-operation reset: the buffer is flushed and the FSM returns to IDLE.
//   The next beat must carry sop or it is counted as an orphan.
// TESTING
//  1 good frame (header match, sop=eop=1, empty=0, meta=252'hA5..) with
//    ready=1 -> out_meta_valid the next cycle with that meta; pkt_cnt=1.
//  Back-to-back 4 good frames, out_meta_ready=0 -> 2 accepted, in_ready=0;
//    then ready=1 -> metas emitted in order, all 4 delivered; pkt_cnt=4.
//  Frame with DST_MAC^1, then one with empty=4 -> no output; drop_cnt=2.
//  3-beat frame (sop, mid, eop), then a good frame -> only the good frame
//    delivered; drop_cnt=1; FSM back in IDLE after the eop beat.
//  Orphan !sop&eop beat, then a good frame -> drop_cnt=1, pkt_cnt=1.
//  Reset asserted with 2 entries buffered -> next cycle out_meta_valid=0,
//    counters=0, in_ready=0 until rst deasserts.

Source files
------------

// File: rtl/meta_extract.sv
// Purpose: receive-side metadata frame checker; validates the single-beat header and unpacks metadata_t.
// Latency: one cycle from an accepted good beat to out_meta_valid when the buffer is empty.
// Backpressure: in_ready drops when the 2-entry output buffer is full; out_meta_ready never reaches in_ready.
module meta_extract #(
  parameter logic [47:0] DST_MAC_P  = 48'h02_11_22_33_44_55,
  parameter logic [47:0] SRC_MAC_P  = 48'h02_66_77_88_99_aa,
  parameter logic [15:0] ETH_TYPE_P = 16'h88b5,
  parameter int          META_W     = 252,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [5:0]        in_empty,
  output logic              in_ready,
  output logic [META_W-1:0] out_meta_data,
  output logic              out_meta_valid,
  input  logic              out_meta_ready,
  output logic [CNT_W-1:0]  stat_pkt_cnt,
  output logic [CNT_W-1:0]  stat_drop_cnt
);

  typedef enum logic {IDLE, DROP} state_t;

  state_t            state;
  state_t            state_n;
  logic [META_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              accept;
  logic              pop;
  logic              push;
  logic              pkt_inc;
  logic              drop_inc;
  logic              hdr_ok;
  logic              unused_pad;

  // The trailing pad of the minimum-size frame carries nothing.
  assign unused_pad = ^in_data[147:0];

  assign hdr_ok = (in_data[511:464] == DST_MAC_P) &&
                  (in_data[463:416] == SRC_MAC_P) &&
                  (in_data[415:400] == ETH_TYPE_P);

  // Ready depends only on the registered occupancy (and reset), so a
  // downstream stall cannot ripple combinationally into the network path.
  assign in_ready       = !rst && (count != 2'd2);
  assign accept         = in_valid && in_ready;
  assign out_meta_valid = (count != 2'd0);
  assign pop            = out_meta_valid && out_meta_ready;
  assign out_meta_data  = out_meta_valid ? mem[rd_ptr] : '0;

  // Frame state register: IDLE expects a new frame, DROP swallows the rest of a rejected one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Classify each accepted beat: push good frames, count rejected frame starts and orphans.
  always_comb begin
    state_n  = state;
    push     = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (in_sop && in_eop) begin
            if (hdr_ok && (in_empty == 6'd0)) begin
              push    = 1'b1;
              pkt_inc = 1'b1;
            end else begin
              drop_inc = 1'b1;
            end
          end else begin
            // Multi-beat frames and orphan beats are both rejected; a beat
            // without eop means more of the same frame is still to come.
            drop_inc = 1'b1;
            if (!in_eop) begin
              state_n = DROP;
            end
          end
        end
        DROP: begin
          // A new sop here is a fresh frame truncating the old one; it is
          // discarded too but still counted.
          if (in_sop) begin
            drop_inc = 1'b1;
          end
          if (in_eop) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Two-entry in-order output buffer; push only happens while not full.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data[399 -: META_W];
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Statistics counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (pkt_inc) begin
        stat_pkt_cnt <= stat_pkt_cnt + 1'b1;
      end
      if (drop_inc) begin
        stat_drop_cnt <= stat_drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_meta_extract.sv
// Bench for meta_extract: directed frames, a queue-based model of delivered
// metadata and counters, and a per-cycle compare against the DUT.
module tb_meta_extract;

  localparam logic [47:0] DST = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SRC = 48'h02_66_77_88_99_aa;
  localparam logic [15:0] ETY = 16'h88b5;
  localparam logic [251:0] META_A = {{31{8'ha5}}, 4'ha};

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_data;
  logic         in_valid;
  logic         in_sop;
  logic         in_eop;
  logic [5:0]   in_empty;
  logic         in_ready;
  logic [251:0] out_meta_data;
  logic         out_meta_valid;
  logic         out_meta_ready;
  logic [31:0]  stat_pkt_cnt;
  logic [31:0]  stat_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: delivered-but-unconsumed metadata, counters, and whether the
  // remainder of a rejected frame is being swallowed.
  logic [251:0] m_q[$];
  logic [31:0]  m_pkt  = 32'd0;
  logic [31:0]  m_drop = 32'd0;
  bit           m_skip = 1'b0;

  logic [251:0] metas [4];

  meta_extract #(
    .DST_MAC_P(DST), .SRC_MAC_P(SRC), .ETH_TYPE_P(ETY), .META_W(252), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid),
    .out_meta_ready(out_meta_ready),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] make_frame(input logic [251:0] meta, input logic [47:0] d,
                                              input logic [47:0] s, input logic [15:0] t);
    return {d, s, t, meta, 148'h5a5};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced on every rising edge from the sampled inputs.
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      m_q.delete();
      m_pkt  = 32'd0;
      m_drop = 32'd0;
      m_skip = 1'b0;
    end else begin
      acc = in_valid && (m_q.size() < 2);
      if (m_q.size() > 0 && out_meta_ready) void'(m_q.pop_front());
      if (acc) begin
        if (m_skip) begin
          if (in_sop) m_drop = m_drop + 32'd1;
          if (in_eop) m_skip = 1'b0;
        end else if (in_sop && in_eop && in_empty == 6'd0 && in_data[511:464] == DST &&
                     in_data[463:416] == SRC && in_data[415:400] == ETY) begin
          m_q.push_back(in_data[399:148]);
          m_pkt = m_pkt + 32'd1;
        end else begin
          m_drop = m_drop + 32'd1;
          if (!in_eop) m_skip = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 256'(in_ready), 256'(!rst && m_q.size() < 2));
      check("out_valid", 256'(out_meta_valid), 256'(m_q.size() != 0));
      if (m_q.size() != 0) check("out_data", 256'(out_meta_data), 256'(m_q[0]));
      check("pkt_cnt", 256'(stat_pkt_cnt), 256'(m_pkt));
      check("drop_cnt", 256'(stat_drop_cnt), 256'(m_drop));
    end
  end

  task automatic send_beat(input logic [511:0] d, input logic s, input logic e, input logic [5:0] emp);
    bit r;
    int n;
    in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_valid = 1'b1;
    r = 1'b0;
    n = 0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles, required acceptance", n);
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 6'd0;
  endtask

  task automatic send_good(input logic [251:0] meta);
    send_beat(make_frame(meta, DST, SRC, ETY), 1'b1, 1'b1, 6'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) metas[i] = 252'h1000 + 252'(i * 17);
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_empty = 6'd0; out_meta_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_valid", 256'(out_meta_valid), 256'(0));
    check("rst_data", 256'(out_meta_data), 256'(0));
    check("rst_pkt", 256'(stat_pkt_cnt), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk); #1;

    // Single good frame: visible next cycle.
    send_good(META_A);
    @(negedge clk);
    check("t1_valid", 256'(out_meta_valid), 256'(1));
    check("t1_data", 256'(out_meta_data), 256'(META_A));
    check("t1_pkt", 256'(stat_pkt_cnt), 256'(1));
    @(posedge clk); #1;

    // Four back-to-back with downstream stalled: buffer fills, then drains in order.
    out_meta_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_good(metas[i]);
      end
      begin
        repeat (6) @(negedge clk);
        check("t2_full_in_ready", 256'(in_ready), 256'(0));
        check("t2_head", 256'(out_meta_data), 256'(metas[0]));
        @(posedge clk); #1;
        out_meta_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    @(negedge clk);
    check("t2_pkt", 256'(stat_pkt_cnt), 256'(5));
    check("t2_empty", 256'(out_meta_valid), 256'(0));
    @(posedge clk); #1;

    // Wrong destination MAC, then non-zero empty.
    send_beat(make_frame(META_A, DST ^ 48'h1, SRC, ETY), 1'b1, 1'b1, 6'd0);
    send_beat(make_frame(META_A, DST, SRC, ETY), 1'b1, 1'b1, 6'd4);
    @(negedge clk);
    check("t3_drop", 256'(stat_drop_cnt), 256'(2));
    check("t3_no_out", 256'(out_meta_valid), 256'(0));
    @(posedge clk); #1;

    // Three-beat frame, then a good one.
    send_beat(make_frame(metas[1], DST, SRC, ETY), 1'b1, 1'b0, 6'd0);
    send_beat(make_frame(metas[2], DST, SRC, ETY), 1'b0, 1'b0, 6'd0);
    send_beat(make_frame(metas[3], DST, SRC, ETY), 1'b0, 1'b1, 6'd0);
    send_good(META_A);
    @(negedge clk);
    check("t4_data", 256'(out_meta_data), 256'(META_A));
    check("t4_drop", 256'(stat_drop_cnt), 256'(3));
    check("t4_pkt", 256'(stat_pkt_cnt), 256'(6));
    @(posedge clk); #1;

    // Orphan end-of-packet beat, then a good frame.
    send_beat(make_frame(metas[0], DST, SRC, ETY), 1'b0, 1'b1, 6'd0);
    send_good(metas[1]);
    @(negedge clk);
    check("t5_drop", 256'(stat_drop_cnt), 256'(4));
    check("t5_pkt", 256'(stat_pkt_cnt), 256'(7));
    @(posedge clk); #1;

    // New sop while discarding: counted each time; sop&eop ends the discard.
    send_beat(make_frame(metas[0], DST, SRC, ETY), 1'b1, 1'b0, 6'd0);
    send_beat(make_frame(metas[0], DST, SRC, ETY), 1'b1, 1'b1, 6'd0);
    send_good(metas[2]);
    @(negedge clk);
    check("t6_drop", 256'(stat_drop_cnt), 256'(6));
    check("t6_pkt", 256'(stat_pkt_cnt), 256'(8));
    check("t6_data", 256'(out_meta_data), 256'(metas[2]));
    @(posedge clk); #1;

    // Reset with two entries buffered.
    out_meta_ready = 1'b0;
    send_good(metas[0]);
    send_good(metas[3]);
    @(negedge clk);
    check("t7_full", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_in_ready", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_flushed", 256'(out_meta_valid), 256'(0));
    check("t7_pkt0", 256'(stat_pkt_cnt), 256'(0));
    check("t7_drop0", 256'(stat_drop_cnt), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    out_meta_ready = 1'b1;
    @(negedge clk);
    check("t7_ready_back", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    send_beat(make_frame(metas[1], DST, SRC, ETY), 1'b0, 1'b1, 6'd0);
    send_good(metas[3]);
    @(negedge clk);
    check("t7_orphan_drop", 256'(stat_drop_cnt), 256'(1));
    check("t7_pkt1", 256'(stat_pkt_cnt), 256'(1));
    check("t7_data", 256'(out_meta_data), 256'(metas[3]));
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
